// File: rtl/tic_tac_toe_input_ctrl.sv
// Player-input front end: button debounce, move validation, X/O strobes.
// Optional idle auto-move when MOVE_TIMEOUT_EN is defined.
module tic_tac_toe_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SETTLE_MAX      = 4,
    parameter int TIMEOUT_CYCLES  = 500000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_confirm,
    input  logic [3:0]  sw_position,
    input  logic [17:0] board,
    input  logic [1:0]  who,
    output logic        playX,
    output logic        playO,
    output logic [3:0]  playerX_position,
    output logic [3:0]  playerO_position,
    output logic        turn,
    output logic        move_err,
    output logic        auto_move,
    output logic        game_over
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam int SW = $clog2(SETTLE_MAX + 1);
    localparam logic [SW-1:0] ST_LAST = SW'(SETTLE_MAX - 1);

    typedef enum logic [1:0] {
        S_WAIT,
        S_ISSUE,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic          sync1, sync2, level, level_d;
    logic [CW-1:0] db_cnt;
    logic          press;
    logic [31:0]   board_ext;
    logic [1:0]    sel_cell, iss_cell;
    logic          board_full, end_cond, move_ok, cell_set;
    logic [3:0]    pos_q;
    logic [SW-1:0] settle_cnt;
    logic          play_x_d, play_o_d, err_d;
    logic          tmo_fire;
    logic [3:0]    free_pos;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            db_cnt  <= '0;
        end else begin
            sync1   <= btn_confirm;
            sync2   <= sync1;
            level_d <= level;
            if (sync2 == level)
                db_cnt <= '0;
            else if (db_cnt == DB_LAST) begin
                level  <= sync2;
                db_cnt <= '0;
            end else
                db_cnt <= db_cnt + 1'b1;
        end
    end

    assign press = level & ~level_d;

    // padded so codes 9..15 index harmless zero bits
    assign board_ext = {14'd0, board};
    assign sel_cell  = board_ext[{sw_position, 1'b0} +: 2];
    assign iss_cell  = board_ext[{pos_q, 1'b0} +: 2];

    always_comb begin
        board_full = 1'b1;
        for (int i = 0; i < 9; i++)
            if (board[2*i +: 2] == 2'b00)
                board_full = 1'b0;
    end

    assign end_cond = (who != 2'b00) | board_full;
    assign move_ok  = (sw_position < 4'd9) && (sel_cell == 2'b00);
    assign cell_set = (iss_cell != 2'b00);

`ifdef MOVE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt;
    logic          auto_q, auto_move_q;

    always_ff @(posedge clk) begin
        if (!rst || state != S_WAIT)
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    always_comb begin
        free_pos = 4'd0;
        for (int i = 8; i >= 0; i--)
            if (board[2*i +: 2] == 2'b00)
                free_pos = 4'(i);
    end

    assign tmo_fire = (state == S_WAIT) && (tmo_cnt == TMO_LAST)
                      && !press && !end_cond;

    always_ff @(posedge clk) begin
        if (!rst) begin
            auto_q      <= 1'b0;
            auto_move_q <= 1'b0;
        end else begin
            if (state == S_WAIT)
                auto_q <= tmo_fire;
            auto_move_q <= (state == S_ISSUE) && auto_q;
        end
    end

    assign auto_move = auto_move_q;
`else
    assign tmo_fire  = 1'b0;
    assign free_pos  = 4'd0;
    // constant false; the timeout length only matters when the feature is built
    assign auto_move = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_nx = state;
        unique case (state)
            S_WAIT: begin
                if (end_cond)
                    state_nx = S_DONE;
                else if (press) begin
                    if (move_ok)
                        state_nx = S_ISSUE;
                end else if (tmo_fire)
                    state_nx = S_ISSUE;
            end
            S_ISSUE:
                state_nx = S_SETTLE;
            S_SETTLE: begin
                if (cell_set)
                    state_nx = end_cond ? S_DONE : S_WAIT;
                else if (settle_cnt == ST_LAST)
                    state_nx = S_WAIT;
            end
            S_DONE:
                state_nx = S_DONE;
        endcase
    end

    always_comb begin
        play_x_d  = (state == S_ISSUE) && !turn;
        play_o_d  = (state == S_ISSUE) && turn;
        err_d     = ((state == S_WAIT) && !end_cond && press && !move_ok)
                  || ((state == S_SETTLE) && !cell_set
                      && (settle_cnt == ST_LAST));
        game_over = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= S_WAIT;
            turn             <= 1'b0;
            pos_q            <= 4'd0;
            settle_cnt       <= '0;
            playX            <= 1'b0;
            playO            <= 1'b0;
            move_err         <= 1'b0;
            playerX_position <= 4'd0;
            playerO_position <= 4'd0;
        end else begin
            state    <= state_nx;
            playX    <= play_x_d;
            playO    <= play_o_d;
            move_err <= err_d;
            if (state == S_WAIT && state_nx == S_ISSUE)
                pos_q <= press ? sw_position : free_pos;
            if (play_x_d)
                playerX_position <= pos_q;
            if (play_o_d)
                playerO_position <= pos_q;
            settle_cnt <= (state == S_SETTLE) ? settle_cnt + 1'b1 : '0;
            if (state == S_SETTLE && cell_set)
                turn <= ~turn;
        end
    end

endmodule

// File: tb/tb_tic_tac_toe_input_ctrl.sv
// Bench for tic_tac_toe_input_ctrl: directed steps plus random games
// checked against a cell-array model of the game rules.
module tb_tic_tac_toe_input_ctrl;

    localparam int DB = 4;
    localparam int SM = 4;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_confirm = 1'b0;
    logic [3:0]  sw_position = 4'd0;
    logic [17:0] board;
    logic [1:0]  who;
    logic [1:0]  who_force = 2'b00;
    logic        core_stall = 1'b0;
    logic        playX, playO, turn, move_err, auto_move, game_over;
    logic [3:0]  playerX_position, playerO_position;

    int n_assert = 0;
    int n_fail = 0;
    int cnt_x = 0, cnt_o = 0, cnt_e = 0, cnt_a = 0;
    logic [3:0] last_px = 4'd0, last_po = 4'd0;

    int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int cells[9];
    int mturn;

    always #5 clk = ~clk;

    tic_tac_toe_input_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .SETTLE_MAX(SM),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_confirm(btn_confirm),
        .sw_position(sw_position),
        .board(board),
        .who(who),
        .playX(playX),
        .playO(playO),
        .playerX_position(playerX_position),
        .playerO_position(playerO_position),
        .turn(turn),
        .move_err(move_err),
        .auto_move(auto_move),
        .game_over(game_over)
    );

    function automatic logic [1:0] core_who(input logic [17:0] b);
        logic [1:0] a, c, d;
        core_who = 2'b00;
        for (int l = 0; l < 8; l++) begin
            a = b[2*lines[l][0] +: 2];
            c = b[2*lines[l][1] +: 2];
            d = b[2*lines[l][2] +: 2];
            if (a != 2'b00 && a == c && c == d)
                core_who = a;
        end
    endfunction

    assign who = core_who(board) | who_force;

    // game core: a strobed cell becomes occupied one cycle later
    always @(posedge clk) begin
        if (!rst)
            board <= '0;
        else if (!core_stall) begin
            if (playX) board[playerX_position*2 +: 2] <= 2'b01;
            if (playO) board[playerO_position*2 +: 2] <= 2'b10;
        end
    end

    always @(negedge clk) begin
        if (playX) begin cnt_x++; last_px = playerX_position; end
        if (playO) begin cnt_o++; last_po = playerO_position; end
        if (move_err) cnt_e++;
        if (auto_move) cnt_a++;
    end

    function automatic bit model_over();
        bit full;
        full = 1'b1;
        for (int i = 0; i < 9; i++)
            if (cells[i] == 0) full = 1'b0;
        model_over = full || (who_force != 2'b00);
        for (int l = 0; l < 8; l++)
            if (cells[lines[l][0]] != 0 &&
                cells[lines[l][0]] == cells[lines[l][1]] &&
                cells[lines[l][1]] == cells[lines[l][2]])
                model_over = 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        btn_confirm = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 9; i++) cells[i] = 0;
        mturn = 0;
        @(negedge clk);
    endtask

    task automatic do_press(input logic [3:0] code, input int glitches,
                            output int nx, output int no, output int ne);
        int bx, bo, be;
        bx = cnt_x; bo = cnt_o; be = cnt_e;
        sw_position = code;
        repeat (glitches) begin
            btn_confirm = 1'b1;
            repeat (3) @(negedge clk);
            btn_confirm = 1'b0;
            repeat (3) @(negedge clk);
        end
        btn_confirm = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 7) sw_position = 4'($urandom_range(0, 15));
            if (k == 8) btn_confirm = 1'b0;
        end
        nx = cnt_x - bx;
        no = cnt_o - bo;
        ne = cnt_e - be;
    endtask

    task automatic play_check(input logic [3:0] code, input int glitches);
        int ex_x, ex_o, ex_e, nx, no, ne;
        ex_x = 0; ex_o = 0; ex_e = 0;
        if (!model_over()) begin
            if (code > 8 || cells[code] != 0)
                ex_e = 1;
            else begin
                if (mturn == 0) ex_x = 1; else ex_o = 1;
                cells[code] = mturn + 1;
                mturn = 1 - mturn;
            end
        end
        do_press(code, glitches, nx, no, ne);
        chk("strobe_x", nx, ex_x);
        chk("strobe_o", no, ex_o);
        chk("move_err", ne, ex_e);
        if (ex_x == 1) chk("pos_x", last_px, code);
        if (ex_o == 1) chk("pos_o", last_po, code);
        chk("turn", turn, mturn);
        chk("game_over", game_over, model_over());
    endtask

    initial begin
        int nx, no, ne, bx, bo, ba;
        logic sx[10];
        logic [3:0] px7;
        @(negedge clk);
        do_reset();
        chk("rst_playX", playX, 0);
        chk("rst_playO", playO, 0);
        chk("rst_move_err", move_err, 0);
        chk("rst_auto_move", auto_move, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_turn", turn, 0);
        chk("rst_pos_x", playerX_position, 0);
        chk("rst_pos_o", playerO_position, 0);

`ifdef MOVE_TIMEOUT_EN
        play_check(4'd0, 0);
        play_check(4'd1, 0);
        bx = cnt_x; bo = cnt_o; ba = cnt_a;
        repeat (25) @(negedge clk);
        chk("tmo_strobe_x", cnt_x - bx, 1);
        chk("tmo_strobe_o", cnt_o - bo, 0);
        chk("tmo_auto_move", cnt_a - ba, 1);
        chk("tmo_pos_x", last_px, 2);
`else
        // exact latency of a clean press
        sw_position = 4'd4;
        btn_confirm = 1'b1;
        px7 = 4'd0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            sx[k] = playX;
            if (k == 7) px7 = playerX_position;
        end
        btn_confirm = 1'b0;
        repeat (12) @(negedge clk);
        chk("lat_before", sx[6], 0);
        chk("lat_strobe", sx[7], 1);
        chk("lat_after", sx[8], 0);
        chk("lat_pos_x", px7, 4);
        chk("lat_turn", turn, 1);
        chk("lat_board", board[9:8], 2'b01);
        cells[4] = 1;
        mturn = 1;

        play_check(4'd0, 3);
        play_check(4'd4, 0);
        play_check(4'd11, 0);

        core_stall = 1'b1;
        do_press(4'd8, 0, nx, no, ne);
        core_stall = 1'b0;
        chk("stall_strobe_x", nx, 1);
        chk("stall_err", ne, 1);
        chk("stall_pos_x", last_px, 8);
        chk("stall_turn", turn, 0);
        play_check(4'd8, 0);

        who_force = 2'b01;
        repeat (3) @(negedge clk);
        chk("win_game_over", game_over, 1);
        play_check(4'd2, 0);
        who_force = 2'b00;
        do_reset();
        chk("win_cleared", game_over, 0);

        // reset lands while the move is in ISSUE
        bx = cnt_x;
        sw_position = 4'd3;
        btn_confirm = 1'b1;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        btn_confirm = 1'b0;
        @(negedge clk);
        chk("midrst_playX", playX, 0);
        chk("midrst_pos_x", playerX_position, 0);
        rst = 1'b1;
        repeat (15) @(negedge clk);
        chk("midrst_strobes", cnt_x - bx, 0);
        chk("midrst_turn", turn, 0);
        chk("midrst_board", board, 0);

        for (int g = 0; g < 3; g++) begin
            do_reset();
            for (int m = 0; m < 30; m++)
                play_check(4'($urandom_range(0, 11)), 0);
        end

        bx = cnt_x; bo = cnt_o; ba = cnt_a;
        do_reset();
        repeat (100) @(negedge clk);
        chk("idle_strobe_x", cnt_x - bx, 0);
        chk("idle_strobe_o", cnt_o - bo, 0);
        chk("idle_auto_move", cnt_a - ba, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tic_tac_toe_input_ctrl.md
# tic_tac_toe_input_ctrl

Player-input front end for the tic-tac-toe game core. It synchronises and debounces one raw confirm button, samples a 4-bit position switch bank, and tracks whose turn it is. It rejects out-of-range or occupied cells locally and issues single-cycle `playX`/`playO` strobes with a stable position code to the game core. It stops accepting moves once the core reports a winner or a full board.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required to accept a button level change (≥2).
- `SETTLE_MAX`, default 4: cycles allowed for the issued cell to appear occupied on `board`.
- `TIMEOUT_CYCLES`, default 500000000: idle cycles per turn before an auto-move (only with `MOVE_TIMEOUT_EN`).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-low.
- `btn_confirm`  in  1  raw asynchronous confirm button, active-high.
- `sw_position`  in  4  requested cell; codes 0–8 map to pos1–pos9, codes 9–15 are invalid.
- `board`  in  18  game-core cells; `board[2k+1:2k]` = pos(k+1); 2'b00 means empty.
- `who`  in  2  winner from the core; non-zero means a win.
- `playX`, `playO`  out  1  one-cycle move strobes.
- `playerX_position`, `playerO_position`  out  4  position code; held from the strobe until the next strobe for that player.
- `turn`  out  1  0 = X to move, 1 = O to move.
- `move_err`  out  1  one-cycle pulse on a rejected move.
- `auto_move`  out  1  one-cycle pulse accompanying a timeout-generated strobe.
- `game_over`  out  1  level; high in DONE.

## Operation
- Button path: two-FF synchroniser, then debounce counter, then rising-edge detect, which produces `press`.
- `board_full` is true when all nine cells are non-zero. `end_cond` = `who != 0` or `board_full`.
- FSM states are WAIT, ISSUE, SETTLE and DONE. The player is selected by `turn`.
- **WAIT**
  - If `end_cond`, go to DONE.
  - Else on `press`, check `sw_position`. If the code is ≥9 or its cell is non-zero, pulse `move_err` and stay in WAIT; `turn` is unchanged.
  - Otherwise latch the code into the current player's position register and go to ISSUE.
- **ISSUE**
  - Assert `playX` (turn=0) or `playO` (turn=1) for exactly one cycle.
  - Go to SETTLE.
- **SETTLE**
  - Wait until the issued cell is non-zero. Then toggle `turn` and return to WAIT, or go to DONE if `end_cond`.
  - If SETTLE_MAX cycles elapse with the cell still empty, pulse `move_err`, keep `turn`, and return to WAIT.
- **DONE**
  - `game_over` = 1. All presses are ignored. The block leaves DONE only on reset.
- `press` arriving in any state other than WAIT is discarded; it is not queued.
- Reset values: state WAIT; `turn`=0; `playX`=`playO`=`move_err`=`auto_move`=`game_over`=0; both position outputs = 4'd0; synchroniser, debounce level and counters = 0.
- Reset wins over every other event in the same cycle, including mid-ISSUE and mid-SETTLE. A strobe in flight is dropped.

## Timing
- The debounce counter increments on each edge where the synchronised input differs from the debounced level. It clears on any edge where they match.
- The level flips on the edge where the counter reaches `DEBOUNCE_CYCLES-1`.
- A clean press first sampled high at edge 0 produces the strobe high during the cycle after edge `DEBOUNCE_CYCLES+3`, provided the FSM is in WAIT.
- Button release follows the same debounce. Only the rising edge produces `press`.
- `sw_position` is sampled only on the `press` cycle; later switch changes have no effect.
- The position output changes on the same edge the strobe rises and stays stable through SETTLE.
- Minimum spacing between two accepted strobes is 3 cycles (ISSUE, SETTLE with 1-cycle acknowledge, WAIT).
- `move_err` rises one cycle after the rejecting edge and lasts one cycle.

## Configuration
- `MOVE_TIMEOUT_EN` defined:
  - A per-turn cycle counter clears on entry to WAIT and increments while in WAIT.
  - On reaching `TIMEOUT_CYCLES-1` with no `press`, the block picks the lowest-numbered empty cell, goes to ISSUE, and pulses `auto_move` together with the strobe.
  - A `press` on the same cycle takes priority over the timeout.
- `MOVE_TIMEOUT_EN` undefined:
  - No counter is built. `auto_move` is tied to 0.
  - WAIT lasts indefinitely.

## Test plan
Bench parameters: `DEBOUNCE_CYCLES`=4, `SETTLE_MAX`=4, `TIMEOUT_CYCLES`=20. A core model sets the cell one cycle after the strobe.
- Reset, then `sw_position`=4 with a clean press → `playX` pulse of 1 cycle, `playerX_position`=4, 7 cycles after the press is first sampled; after the settle, `turn`=1.
- Button bounce of 3-cycle high glitches, then a stable press → exactly one `playO` strobe.
- `sw_position`=4 (occupied), then 11 → two `move_err` pulses, no strobes, `turn` unchanged.
- Core model never fills the cell → `move_err` after 4 SETTLE cycles; the same player's next valid press is accepted.
- Core asserts `who`=2'b01 → `game_over`=1; further presses produce no strobes until `rst`=0.
- With `MOVE_TIMEOUT_EN`: cells pos1 and pos2 filled, no press for 20 cycles → strobe with position=2 and `auto_move`=1. Without the macro, no strobe after 100 idle cycles.
